fdsync_bank: RTL and testbench

Parametrised, double-buffered register bank for the Tom register file, generalising the 16-bit load-enabled synchronous register to CHANNELS × WIDTH. CPU-side writes land in per-channel shadow registers with byte-lane enables. A single commit strobe (typically vertical blank) transfers all dirty shadows to the active registers that drive the video and object logic. Channels selected by IMMEDIATE_MASK bypass the shadow stage.

---
 rtl/fdsync_pkg.sv | 15 +
 rtl/fdsync_bank_if.sv | 49 ++++
 rtl/fdsync_chan.sv | 66 ++++++
 rtl/fdsync_bank.sv | 81 ++++++++
 tb/tb_fdsync_bank.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fdsync_pkg.sv
// Shared sizing helpers and defaults
// for the double-buffered register bank.
package fdsync_pkg;

  localparam logic [63:0] FDS_RESET_VAL = '0;

  function automatic int lanes(input int w);
    return w / 8;
  endfunction

  function automatic int clog2m1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fdsync_bank_if.sv
// CPU-side write/commit/readback bus
// of the register bank.
interface fdsync_bank_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  import fdsync_pkg::*;

  localparam int AW = clog2m1(CHANNELS);
  localparam int LN = lanes(WIDTH);

  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [LN-1:0] wr_be;
  logic [WIDTH-1:0] wr_data;
  logic          commit;
  logic [AW-1:0] rd_addr;
  logic          rd_shadow;
  logic [WIDTH-1:0] rd_data;
  logic          committed;
  logic          wr_err;

  modport master (
    output wr,
    output wr_addr,
    output wr_be,
    output wr_data,
    output commit,
    output rd_addr,
    output rd_shadow,
    input  rd_data,
    input  committed,
    input  wr_err
  );

  modport slave (
    input  wr,
    input  wr_addr,
    input  wr_be,
    input  wr_data,
    input  commit,
    input  rd_addr,
    input  rd_shadow,
    output rd_data,
    output committed,
    output wr_err
  );

endinterface

// File: rtl/fdsync_chan.sv
// One bank channel: shadow, active,
// dirty flag and byte-lane merge.
module fdsync_chan
  import fdsync_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit IMMEDIATE = 1'b0
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             we,
  input  logic [lanes(WIDTH)-1:0] be,
  input  logic [WIDTH-1:0] data,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active,
  output logic             dirty,
  output logic             moved
);

  localparam int LN = lanes(WIDTH);

  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] shadow_nx;
  logic             hit;

  assign hit = we && (|be);

  always_comb begin
    merged = shadow;
    for (int i = 0; i < LN; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  assign shadow_nx = hit ? merged : shadow;

  // a same-cycle write counts as dirty
  assign moved = !IMMEDIATE && commit
              && (dirty || hit);

  always_ff @(posedge clk) begin
    if (!resetl) begin
      shadow <= RESET_VAL;
      active <= RESET_VAL;
      dirty  <= 1'b0;
    end else begin
      shadow <= shadow_nx;
      if (IMMEDIATE) begin
        dirty <= 1'b0;
        if (hit) begin
          active <= merged;
        end
      end else if (moved) begin
        active <= shadow_nx;
        dirty  <= 1'b0;
      end else if (hit) begin
        dirty <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdsync_bank.sv
// CHANNELS x WIDTH double-buffered bank
// with commit strobe and readback.
module fdsync_bank
  import fdsync_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter logic [WIDTH-1:0] RESET_VAL =
    FDS_RESET_VAL[WIDTH-1:0],
  parameter logic [CHANNELS-1:0] IMMEDIATE_MASK = '0
) (
  input  logic                      sys_clk,
  input  logic                      resetl,
  fdsync_bank_if.slave              bus,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       dirty,
  output logic                      pending
);

  localparam int AW = clog2m1(CHANNELS);
  localparam logic [AW:0] CH_LIM = CHANNELS;

  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [CHANNELS-1:0] we;
  logic [CHANNELS-1:0] moved;
  logic [WIDTH-1:0]    rd_nx;
  logic                addr_ok;

  assign addr_ok = {1'b0, bus.wr_addr} < CH_LIM;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign we[c] = bus.wr && addr_ok
                && (bus.wr_addr == AW'(c));

    fdsync_chan #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL),
      .IMMEDIATE (IMMEDIATE_MASK[c])
    ) u_chan (
      .clk    (sys_clk),
      .resetl (resetl),
      .we     (we[c]),
      .be     (bus.wr_be),
      .data   (bus.wr_data),
      .commit (bus.commit),
      .shadow (shadow[c]),
      .active (active[c]),
      .dirty  (dirty[c]),
      .moved  (moved[c])
    );

    assign q[c*WIDTH +: WIDTH] = active[c];
  end

  assign pending = |dirty;

  // out-of-range rd_addr matches nothing
  always_comb begin
    rd_nx = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.rd_addr == AW'(c)) begin
        rd_nx = bus.rd_shadow ? shadow[c]
                              : active[c];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      bus.rd_data   <= '0;
      bus.committed <= 1'b0;
      bus.wr_err    <= 1'b0;
    end else begin
      bus.rd_data   <= rd_nx;
      bus.committed <= |moved;
      bus.wr_err    <= bus.wr && !addr_ok;
    end
  end

endmodule

// File: tb/tb_fdsync_bank.sv
// Self-checking bench: vector table with
// scoreboard plus mask / range sequences.
module tb_fdsync_bank;

  logic sys_clk = 1'b0;
  logic resetl;
  always #5 sys_clk = ~sys_clk;

  fdsync_bank_if #(.WIDTH(16), .CHANNELS(4)) b0 ();
  fdsync_bank_if #(.WIDTH(16), .CHANNELS(4)) b1 ();
  fdsync_bank_if #(.WIDTH(16), .CHANNELS(3)) b2 ();

  logic [63:0] q0, q1;
  logic [47:0] q2;
  logic [3:0]  d0, d1;
  logic [2:0]  d2;
  logic        p0, p1, p2;

  fdsync_bank #(.WIDTH(16), .CHANNELS(4)) u0 (
    .sys_clk(sys_clk), .resetl(resetl), .bus(b0),
    .q(q0), .dirty(d0), .pending(p0));

  fdsync_bank #(.WIDTH(16), .CHANNELS(4),
    .IMMEDIATE_MASK(4'b1000)) u1 (
    .sys_clk(sys_clk), .resetl(resetl), .bus(b1),
    .q(q1), .dirty(d1), .pending(p1));

  fdsync_bank #(.WIDTH(16), .CHANNELS(3)) u2 (
    .sys_clk(sys_clk), .resetl(resetl), .bus(b2),
    .q(q2), .dirty(d2), .pending(p2));

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [1:0]  addr;
    logic [1:0]  be;
    logic [15:0] data;
    logic        commit;
    logic [1:0]  rd_addr;
    logic        rd_sh;
  } stim_t;

  typedef struct {
    logic [63:0] q;
    logic [3:0]  dirty;
    logic        cmt;
    logic        err;
    logic [15:0] rd;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs [15];
  exp_t sbq [$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic r, input logic w,
    input logic [1:0] a, input logic [1:0] be,
    input logic [15:0] d, input logic c,
    input logic [1:0] ra, input logic rs,
    input logic [63:0] eq, input logic [3:0] ed,
    input logic ec, input logic [15:0] erd);
    vec_t v;
    v.s = '{r, w, a, be, d, c, ra, rs};
    v.e = '{eq, ed, ec, 1'b0, erd};
    return v;
  endfunction

  task automatic idle_all();
    b0.wr = 0; b0.commit = 0; b0.wr_addr = 0;
    b0.wr_be = 0; b0.wr_data = 0;
    b0.rd_addr = 0; b0.rd_shadow = 0;
    b1.wr = 0; b1.commit = 0; b1.wr_addr = 0;
    b1.wr_be = 0; b1.wr_data = 0;
    b1.rd_addr = 0; b1.rd_shadow = 0;
    b2.wr = 0; b2.commit = 0; b2.wr_addr = 0;
    b2.wr_be = 0; b2.wr_data = 0;
    b2.rd_addr = 0; b2.rd_shadow = 0;
  endtask

  initial begin
    resetl = 1'b0;
    idle_all();

    vecs[0]  = mk(0,1,1,3,16'hFFFF,0,0,0,
                  64'h0,4'b0000,0,16'h0);
    vecs[1]  = mk(0,1,1,3,16'hFFFF,0,0,0,
                  64'h0,4'b0000,0,16'h0);
    vecs[2]  = mk(1,1,1,1,16'hABCD,0,1,1,
                  64'h0,4'b0010,0,16'h0);
    vecs[3]  = mk(1,0,0,0,16'h0,0,1,1,
                  64'h0,4'b0010,0,16'h00CD);
    vecs[4]  = mk(1,0,0,0,16'h0,1,1,0,
                  64'h0000_0000_00CD_0000,
                  4'b0000,1,16'h0);
    vecs[5]  = mk(1,0,0,0,16'h0,0,1,0,
                  64'h0000_0000_00CD_0000,
                  4'b0000,0,16'h00CD);
    vecs[6]  = mk(1,1,2,3,16'h1234,1,2,0,
                  64'h0000_1234_00CD_0000,
                  4'b0000,1,16'h0);
    vecs[7]  = mk(1,0,0,0,16'h0,1,2,0,
                  64'h0000_1234_00CD_0000,
                  4'b0000,0,16'h1234);
    vecs[8]  = mk(1,1,0,0,16'hFFFF,0,0,1,
                  64'h0000_1234_00CD_0000,
                  4'b0000,0,16'h0);
    vecs[9]  = mk(1,1,1,2,16'hABCD,0,1,1,
                  64'h0000_1234_00CD_0000,
                  4'b0010,0,16'h00CD);
    vecs[10] = mk(1,1,2,1,16'h0055,0,1,1,
                  64'h0000_1234_00CD_0000,
                  4'b0110,0,16'hABCD);
    vecs[11] = mk(0,1,3,3,16'h7777,1,2,1,
                  64'h0,4'b0000,0,16'h0);
    vecs[12] = mk(1,0,0,0,16'h0,0,2,1,
                  64'h0,4'b0000,0,16'h0);
    vecs[13] = mk(1,1,3,3,16'hBEEF,0,3,1,
                  64'h0,4'b1000,0,16'h0);
    vecs[14] = mk(1,0,0,0,16'h0,1,3,1,
                  64'hBEEF_0000_0000_0000,
                  4'b0000,1,16'hBEEF);

    @(negedge sys_clk);
    for (int i = 0; i < 15; i++) begin
      resetl       = vecs[i].s.rst_n;
      b0.wr        = vecs[i].s.wr;
      b0.wr_addr   = vecs[i].s.addr;
      b0.wr_be     = vecs[i].s.be;
      b0.wr_data   = vecs[i].s.data;
      b0.commit    = vecs[i].s.commit;
      b0.rd_addr   = vecs[i].s.rd_addr;
      b0.rd_shadow = vecs[i].s.rd_sh;
      sbq.push_back(vecs[i].e);
      tick();
      e = sbq.pop_front();
      chk($sformatf("v%0d q", i), q0, e.q);
      chk($sformatf("v%0d dirty", i),
          {60'h0, d0}, {60'h0, e.dirty});
      chk($sformatf("v%0d pending", i),
          {63'h0, p0}, {63'h0, |e.dirty});
      chk($sformatf("v%0d committed", i),
          {63'h0, b0.committed}, {63'h0, e.cmt});
      chk($sformatf("v%0d wr_err", i),
          {63'h0, b0.wr_err}, {63'h0, e.err});
      chk($sformatf("v%0d rd_data", i),
          {48'h0, b0.rd_data}, {48'h0, e.rd});
    end
    idle_all();

    resetl = 1'b0;
    tick();
    resetl = 1'b1;
    b1.wr = 1; b1.wr_addr = 3;
    b1.wr_be = 2'b11; b1.wr_data = 16'hBEEF;
    tick();
    b1.wr = 0;
    chk("imm q", q1, 64'hBEEF_0000_0000_0000);
    chk("imm dirty", {60'h0, d1}, 64'h0);
    chk("imm nocmt", {63'h0, b1.committed}, 64'h0);
    b1.commit = 1;
    b1.rd_addr = 3; b1.rd_shadow = 1;
    tick();
    b1.commit = 0;
    chk("imm commit pulse",
        {63'h0, b1.committed}, 64'h0);
    chk("imm q hold", q1, 64'hBEEF_0000_0000_0000);
    chk("imm shadow", {48'h0, b1.rd_data},
        64'hBEEF);
    b1.wr = 1; b1.wr_addr = 0;
    b1.wr_be = 2'b11; b1.wr_data = 16'h4242;
    tick();
    b1.wr = 0;
    chk("mix dirty", {60'h0, d1}, 64'h1);
    chk("mix q", q1, 64'hBEEF_0000_0000_0000);

    b2.wr = 1; b2.wr_addr = 2;
    b2.wr_be = 2'b11; b2.wr_data = 16'h5A5A;
    b2.commit = 1;
    tick();
    b2.wr = 0; b2.commit = 0;
    chk("c3 q", {16'h0, q2}, 64'h5A5A_0000_0000);
    chk("c3 cmt", {63'h0, b2.committed}, 64'h1);
    b2.wr = 1; b2.wr_addr = 3;
    b2.wr_be = 2'b11; b2.wr_data = 16'hFFFF;
    b2.rd_addr = 2; b2.rd_shadow = 0;
    tick();
    b2.wr = 0;
    chk("c3 wr_err", {63'h0, b2.wr_err}, 64'h1);
    chk("c3 drop dirty", {61'h0, d2}, 64'h0);
    chk("c3 drop q", {16'h0, q2}, 64'h5A5A_0000_0000);
    chk("c3 rd2", {48'h0, b2.rd_data}, 64'h5A5A);
    b2.rd_addr = 3;
    tick();
    chk("c3 err clr", {63'h0, b2.wr_err}, 64'h0);
    b2.rd_shadow = 1;
    tick();
    chk("c3 rd3", {48'h0, b2.rd_data}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
